gray_counter: RTL
=================

Name: gray_counter

Overview:
- Parametrised up/down counter whose primary output is a registered Gray code; a registered binary copy is also provided.
- Successor to the fixed 4-bit combinational binary-to-Gray conversion: adds width generalisation, state, load, direction, saturate/wrap mode and event flags.
- Intended for async-FIFO read/write pointers and other clock-domain-crossing counters. Only one bit of gray_o changes per count step, and every output comes straight from a flop.

Parameters:
- WIDTH, 4: counter width in bits; legal range 2..32.
- RESET_VAL, 0: binary value loaded on reset; must be < 2**WIDTH.
- SATURATE, 0: 0 = wrap at the ends of the range; 1 = hold at the end value instead of wrapping.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up_dn  input  1  count direction; 1 = increment, 0 = decrement.
- load  input  1  synchronous load of load_bin.
- load_bin  input  WIDTH  binary value to load.
- gray_o  output  WIDTH  registered Gray code of the count.
- bin_o  output  WIDTH  registered binary count.
- wrap_o  output  1  registered one-cycle pulse when the count wraps.
- sat_o  output  1  registered level; high while SATURATE=1 and the counter is blocked at an end value.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: clk and rst only, no asynchronous paths.
- All outputs are registered. No combinational path from any input to any output; latency from the control inputs to the outputs is one cycle.
- Priority per rising edge, highest first: rst, load, en, hold.
- rst:
  - bin_o <= RESET_VAL.
  - gray_o <= RESET_VAL ^ (RESET_VAL >> 1).
  - wrap_o <= 0, sat_o <= 0.
  - rst asserted mid-count takes effect at the next edge and overrides load and en in that cycle.
- load (rst low):
  - bin_o <= load_bin; gray_o <= Gray(load_bin).
  - wrap_o <= 0.
  - sat_o <= 1 only if SATURATE=1, en=1, and load_bin is the end value in the up_dn direction; otherwise 0.
  - en is ignored in the load cycle (no count step).
- count (rst, load low, en high):
  - up_dn=1 and bin_o < MAX (MAX = 2**WIDTH-1): bin_o+1.
  - up_dn=0 and bin_o > 0: bin_o-1.
  - At an end value with SATURATE=0: wrap (MAX -> 0 up, 0 -> MAX down), wrap_o <= 1 for that single cycle.
  - At an end value with SATURATE=1: value held, wrap_o <= 0, sat_o <= 1.
  - sat_o deasserts on the first cycle the counter moves, or when en is low.
- hold (en low): bin_o and gray_o unchanged; wrap_o <= 0; sat_o <= 0.
- Arithmetic is modulo 2**WIDTH on the binary register. gray_o is next_bin ^ (next_bin >> 1), registered from the same next-state value so that gray_o and bin_o are always coherent.
- Invariants checked every cycle after reset:
  - gray_o == bin_o ^ (bin_o >> 1).
  - Hamming distance between consecutive gray_o values is exactly 1 on a count step (including wrap).
  - Hamming distance is 0 when holding or saturated.
  - A load may change any number of bits.
- Direction may change on any cycle with no dead cycle.
- X on en, up_dn or load while rst is high has no effect.

Test Plan:
- Reset, then en=1 with up_dn=1 for 16 cycles (WIDTH=4, SATURATE=0):
  - gray_o sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
  - wrap_o pulses exactly once, on the 8 -> 0 step.
  - Single-bit change on every step.
- Reset, then up_dn=0 count:
  - bin_o 0 -> F, gray_o 0 -> 8, wrap_o=1 on that step.
  - Next step: bin_o E, gray_o 9, wrap_o=0.
- SATURATE=1, load_bin=E, then count up 3 cycles:
  - bin_o E, F, F, F.
  - sat_o=1 from the cycle bin_o first reads F, gray_o stays 8, wrap_o never asserts.
  - Switch up_dn=0: bin_o E, sat_o=0.
- Load priority:
  - load=1, en=1, load_bin=5: bin_o=5, gray_o=7 next cycle, no increment.
  - Following cycle with en=1, up_dn=1: bin_o=6, gray_o=5.
- Reset mid-operation (RESET_VAL=3):
  - rst=1 together with load=1 and en=1: bin_o=3, gray_o=2, wrap_o=0, sat_o=0.
  - Outputs hold those values while rst stays high.
- Width sweep, WIDTH=2 and WIDTH=8, random en/up_dn/load for 10k cycles:
  - Gray/binary coherence and the single-bit-step invariant hold.
  - A scoreboard model matches bin_o every cycle.

Source files
------------

// File: rtl/gray_counter.sv
// -----------------------------------------------------------------------------
// gray_counter
// Parametrised up/down counter with a registered Gray-code output and a
// registered binary copy. Intended for clock-domain-crossing pointers such as
// async-FIFO read/write pointers: every output comes straight from a flop and
// gray_o changes by exactly one bit on each count step (including wrap).
//
// Parameters
//   WIDTH     : counter width in bits (2..32)
//   RESET_VAL : binary value taken on reset (< 2**WIDTH)
//   SATURATE  : 0 = wrap at the range ends, 1 = hold at the end value
//
// Ports
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset (highest priority)
//   en       : count enable, one step per cycle while high
//   up_dn    : direction, 1 = increment, 0 = decrement
//   load     : synchronous load of load_bin (beats en)
//   load_bin : binary value to load
//   gray_o   : registered Gray code of the count
//   bin_o    : registered binary count
//   wrap_o   : registered one-cycle pulse on a wrap step
//   sat_o    : registered level, high while saturated at an end value
// -----------------------------------------------------------------------------
module gray_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray_o,
  output logic [WIDTH-1:0] bin_o,
  output logic             wrap_o,
  output logic             sat_o
);

  localparam logic [WIDTH-1:0] RST_BIN  = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Binary to reflected Gray code.
  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // True when v is the end of the range in the given direction.
  function automatic logic is_end(input logic [WIDTH-1:0] v, input logic up);
    return up ? (v == MAX_VAL) : (v == ZERO_VAL);
  endfunction

  logic [WIDTH-1:0] bin_q,  bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             sat_q,  sat_d;
  logic             at_end_s;

  // Next-state computation: load beats count beats hold (rst is applied in the flop block).
  always_comb begin
    bin_d    = bin_q;
    wrap_d   = 1'b0;
    sat_d    = 1'b0;
    at_end_s = is_end(bin_q, up_dn);
    if (load) begin
      bin_d = load_bin;
      // Loading the end value while counting towards it means the next step is blocked.
      sat_d = SATURATE && en && is_end(load_bin, up_dn);
    end else if (en) begin
      if (SATURATE && at_end_s) begin
        bin_d = bin_q;
        sat_d = 1'b1;
      end else begin
        bin_d  = up_dn ? (bin_q + ONE_VAL) : (bin_q - ONE_VAL);
        wrap_d = at_end_s;
        // Arriving at the end value flags saturation from that cycle on.
        sat_d  = SATURATE && is_end(bin_d, up_dn);
      end
    end else begin
      bin_d = bin_q;
    end
    // Gray is derived from the same next-state value so bin_o and gray_o stay coherent.
    gray_d = bin2gray(bin_d);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= RST_BIN;
      gray_q <= bin2gray(RST_BIN);
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign bin_o  = bin_q;
  assign gray_o = gray_q;
  assign wrap_o = wrap_q;
  assign sat_o  = sat_q;

endmodule
